// File: rtl/sprite_loader.sv
// sprite_loader: streams one SPRITE_W x SPRITE_H sprite into a frame RAM bank,
// one registered write per accepted pixel, while counting key-colour pixels.
module sprite_loader #(
   parameter int          SPRITE_W  = 32,
   parameter int          SPRITE_H  = 32,
   parameter logic [23:0] KEY_COLOR = 24'hFF0000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [1:0]  bank,
   input  logic        abort,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        wr_en,
   output logic [1:0]  wr_bank,
   output logic [9:0]  wr_addr,
   output logic [23:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [10:0] key_count
);

   localparam int XW = $clog2(SPRITE_W);
   localparam int YW = $clog2(SPRITE_H);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t        r_state;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_wr_en;
   logic [1:0]    r_wr_bank;
   logic [9:0]    r_wr_addr;
   logic [23:0]   r_wr_data;
   logic          r_done;
   logic [10:0]   r_key_count;

   logic w_accept;
   logic w_last_pix;

   assign pix_ready  = (r_state == S_LOAD) && !abort;
   assign w_accept   = pix_valid && pix_ready;
   assign w_last_pix = (r_x == XW'(SPRITE_W - 1)) && (r_y == YW'(SPRITE_H - 1));

   assign busy      = (r_state == S_LOAD);
   assign wr_en     = r_wr_en;
   assign wr_bank   = r_wr_bank;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign done      = r_done;
   assign key_count = r_key_count;

   // NOTE: every register here updates with <= so all of them see the
   // pre-edge values of their neighbours, exactly like the flops they become.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_wr_en     <= 1'b0;
         r_wr_bank   <= 2'd0;
         r_wr_addr   <= 10'd0;
         r_wr_data   <= 24'd0;
         r_done      <= 1'b0;
         r_key_count <= 11'd0;
      end else begin
         r_wr_en <= w_accept;
         r_done  <= 1'b0;
         // Address and data only move on an acceptance, so they hold otherwise.
         if (w_accept) begin
            r_wr_addr <= 10'({r_y, r_x});
            r_wr_data <= pix_data;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wr_bank   <= bank;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_key_count <= 11'd0;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  if (pix_data == KEY_COLOR) r_key_count <= r_key_count + 11'd1;
                  if (r_x == XW'(SPRITE_W - 1)) begin
                     r_x <= '0;
                     r_y <= r_y + YW'(1);
                  end else begin
                     r_x <= r_x + XW'(1);
                  end
                  if (w_last_pix) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: randomized and directed loads checked cycle by cycle
// against a pixel-count reference model of the sprite loader.
module tb_sprite_loader;

   localparam int          NPIX = 1024;
   localparam logic [23:0] KEY  = 24'hFF0000;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        start;
   logic [1:0]  bank;
   logic        abort;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        wr_en;
   logic [1:0]  wr_bank;
   logic [9:0]  wr_addr;
   logic [23:0] wr_data;
   logic        busy;
   logic        done;
   logic [10:0] key_count;

   sprite_loader dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .start    (start),
      .bank     (bank),
      .abort    (abort),
      .pix_data (pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .wr_en    (wr_en),
      .wr_bank  (wr_bank),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .key_count(key_count)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: "loading" flag plus number of pixels taken so far.
   bit   m_load;
   bit   m_done;
   int   m_cnt;
   int   m_key;
   logic [31:0] e_wr_en, e_addr, e_data, e_bank, e_done;

   // Observed activity, cleared per scenario.
   int obs_writes;
   int obs_dones;
   logic [31:0] obs_key_at_done;
   logic [31:0] obs_addr_at_done;
   logic [31:0] obs_wren_at_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_load = 1'b0; m_done = 1'b0; m_cnt = 0; m_key = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_bank = 0; e_done = 0;
   endtask

   task automatic clear_obs();
      obs_writes = 0; obs_dones = 0;
      obs_key_at_done = 0; obs_addr_at_done = 0; obs_wren_at_done = 0;
   endtask

   // One clock cycle: entered and left on a falling edge.
   task automatic step(input logic s, input logic [1:0] b, input logic a,
                       input logic v, input logic [23:0] d);
      bit acc, was_load, was_done;
      start = s; bank = b; abort = a; pix_valid = v; pix_data = d;
      #1;
      check("pix_ready", 32'(pix_ready), 32'(m_load && !a));
      check("busy", 32'(busy), 32'(m_load));
      acc      = v && m_load && !a;
      was_load = m_load;
      was_done = m_done;
      e_wr_en  = 32'(acc);
      e_done   = 0;
      if (acc) begin
         e_addr = 32'(m_cnt);
         e_data = 32'(d);
         if (d == KEY) m_key++;
         m_cnt++;
      end
      if (was_done) begin
         m_done = 1'b0;
      end else if (!was_load) begin
         if (s) begin
            m_load = 1'b1; m_cnt = 0; m_key = 0; e_bank = 32'(b);
         end
      end else if (a) begin
         m_load = 1'b0;
      end else if (acc && m_cnt == NPIX) begin
         m_load = 1'b0; m_done = 1'b1; e_done = 1;
      end
      @(posedge Clk);
      @(negedge Clk);
      check("wr_en", 32'(wr_en), e_wr_en);
      check("wr_addr", 32'(wr_addr), e_addr);
      check("wr_data", 32'(wr_data), e_data);
      check("wr_bank", 32'(wr_bank), e_bank);
      check("done", 32'(done), e_done);
      check("key_count", 32'(key_count), 32'(m_key));
      if (wr_en) obs_writes++;
      if (done) begin
         obs_dones++;
         obs_key_at_done  = 32'(key_count);
         obs_addr_at_done = 32'(wr_addr);
         obs_wren_at_done = 32'(wr_en);
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 24'd0);
   endtask

   initial begin
      Reset_n = 1'b0; start = 1'b0; bank = 2'd0; abort = 1'b0;
      pix_valid = 1'b0; pix_data = 24'd0;
      model_reset();
      clear_obs();
      repeat (3) @(negedge Clk);
      #1;
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_key_count", 32'(key_count), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      idle_steps(2);

      // Full back-to-back load into bank 2 with pixel value = index.
      clear_obs();
      step(1'b1, 2'd2, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < NPIX; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 24'(i));
      idle_steps(3);
      check("full_writes", 32'(obs_writes), 32'(NPIX));
      check("full_dones", 32'(obs_dones), 1);
      check("full_done_wr_en", obs_wren_at_done, 1);
      check("full_done_addr", obs_addr_at_done, 32'(NPIX - 1));

      // Random stalls, random data, spurious starts with other banks.
      begin
         int cyc;
         clear_obs();
         step(1'b1, 2'd1, 1'b0, 1'b0, 24'd0);
         cyc = 0;
         while ((m_load || m_done) && cyc < 6000) begin
            logic        v;
            logic [23:0] d;
            v = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom());
            step($urandom_range(0, 9) == 0, 2'($urandom()), 1'b0, v, d);
            cyc++;
         end
         idle_steps(2);
         check("stall_end_busy", 32'(busy), 0);
         check("stall_writes", 32'(obs_writes), 32'(NPIX));
         check("stall_dones", 32'(obs_dones), 1);
      end

      // Every 4th pixel is the key colour.
      clear_obs();
      step(1'b1, 2'd0, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < NPIX; i++)
         step(1'b0, 2'd0, 1'b0, 1'b1, (i % 4 == 0) ? KEY : 24'($urandom() & 32'h00FFFF));
      idle_steps(2);
      check("key_dones", 32'(obs_dones), 1);
      check("key_at_done", obs_key_at_done, 256);

      // Row wrap, ignored start, abort with a valid pixel present, restart.
      clear_obs();
      step(1'b1, 2'd3, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 33; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 24'($urandom()));
      check("wrap_addr", 32'(wr_addr), 32);
      step(1'b1, 2'd0, 1'b0, 1'b1, 24'($urandom()));
      check("ignored_start_bank", 32'(wr_bank), 3);
      for (int i = 0; i < 66; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 24'($urandom()));
      step(1'b0, 2'd0, 1'b1, 1'b1, 24'h123456);
      idle_steps(3);
      check("abort_writes", 32'(obs_writes), 100);
      check("abort_dones", 32'(obs_dones), 0);
      step(1'b1, 2'd1, 1'b0, 1'b0, 24'd0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 24'hABCDEF);
      check("restart_wr_en", 32'(wr_en), 1);
      check("restart_addr", 32'(wr_addr), 0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 24'd0);
      idle_steps(2);

      // Asynchronous reset in the middle of a load.
      clear_obs();
      step(1'b1, 2'd2, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 500; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 24'($urandom() | 32'h1));
      #2;
      Reset_n = 1'b0;
      #1;
      check("arst_wr_en", 32'(wr_en), 0);
      check("arst_wr_addr", 32'(wr_addr), 0);
      check("arst_wr_data", 32'(wr_data), 0);
      check("arst_wr_bank", 32'(wr_bank), 0);
      check("arst_key_count", 32'(key_count), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_pix_ready", 32'(pix_ready), 0);
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
      clear_obs();
      for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 24'($urandom()));
      check("arst_no_writes", 32'(obs_writes), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, meaning sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPRITE_H, default 32, meaning sprite height in pixels (power of two).
REQ-003 SHALL have parameter KEY_COLOR, default 24'hFF0000, meaning the transparent key colour.
REQ-004 SHALL have port Clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  request to begin loading one sprite.
REQ-007 SHALL have port bank  input  2  target sprite bank: 0 up, 1 right, 2 left, 3 down.
REQ-008 SHALL have port abort  input  1  cancel the load in progress.
REQ-009 SHALL have port pix_data  input  24  incoming pixel, packed {R,G,B}.
REQ-010 SHALL have port pix_valid  input  1  pix_data is valid.
REQ-011 SHALL have port pix_ready  output  1  loader accepts a pixel this cycle.
REQ-012 SHALL have port wr_en  output  1  frame RAM write strobe.
REQ-013 SHALL have port wr_bank  output  2  bank being written.
REQ-014 SHALL have port wr_addr  output  10  frame RAM address, x + y*SPRITE_W.
REQ-015 SHALL have port wr_data  output  24  pixel written.
REQ-016 SHALL have port busy  output  1  high in LOAD.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port key_count  output  11  number of KEY_COLOR pixels in the last completed or current load.

Function
REQ-019 SHALL implement states IDLE, LOAD, DONE.
REQ-020 IDLE: start=1 SHALL latch bank into wr_bank, clear x, y and key_count, and move to LOAD next cycle.
REQ-021 start SHALL be ignored in LOAD and DONE; bank SHALL be sampled only on an accepted start.
REQ-022 pix_ready SHALL be combinational: (state==LOAD) && !abort.
REQ-023 A pixel SHALL be accepted only on a cycle where pix_valid && pix_ready.
REQ-024 Accepted pixel in cycle N SHALL produce wr_en=1 in cycle N+1 with wr_addr={y,x} as sampled in cycle N and wr_data=pix_data as sampled in cycle N; latency is exactly 1.
REQ-025 wr_en SHALL be 0 in every cycle not immediately following an acceptance; wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-026 x SHALL increment per acceptance and wrap from SPRITE_W-1 to 0, incrementing y; no gaps or reordering.
REQ-027 pix_valid=0 in LOAD SHALL stall counters with no write issued.
REQ-028 An accepted pixel equal to KEY_COLOR SHALL increment key_count; the pixel is still written.
REQ-029 Acceptance of pixel x=SPRITE_W-1, y=SPRITE_H-1 SHALL move to DONE; the final write occurs in the DONE cycle.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE; pix_ready=0 in DONE.
REQ-031 abort=1 in LOAD SHALL return to IDLE next cycle; no pixel is accepted that cycle, done stays 0, key_count holds its partial value.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 busy SHALL equal (state==LOAD).

Reset
REQ-034 Reset_n=0 SHALL immediately, regardless of Clk, force IDLE and clear x, y, wr_en, wr_bank, wr_addr, wr_data, done and key_count to 0.
REQ-035 Reset asserted mid-load SHALL discard the load, including any pending write; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-036 Full load: start with bank=2, then 1024 back-to-back valid pixels of value i -> 1024 writes with wr_addr=i and wr_data=i, each one cycle after acceptance, wr_bank=2, done pulses once in the cycle of the last write.
REQ-037 Stalls: random pix_valid gaps during a full load -> same address/data sequence, wr_en only after acceptances, done exactly once.
REQ-038 Key count: 1024 pixels, every 4th equal to 24'hFF0000 -> key_count=256 at done.
REQ-039 Wrap: 33rd accepted pixel -> wr_addr=32 (x=0, y=1); start asserted during LOAD -> ignored, bank unchanged.
REQ-040 Abort: abort after 100 pixels, with pix_valid=1 on the same cycle -> pix_ready=0 that cycle, exactly 100 writes, no done; a new start restarts at wr_addr=0.
REQ-041 Reset mid-load: Reset_n low for 1 cycle after 500 pixels -> outputs 0 asynchronously, no further writes, state IDLE.
